fpu_arbiter: RTL and testbench

- Shares one floating-point execution unit (adder, multiplier or divider back-end, selected by an opcode) between N_REQ requesters.
- Uses round-robin arbitration and a valid/ready request handshake.
- Runs one operation at a time, with a response timeout and a unit flush on timeout.
- Sits between the client logic and the execution-unit wrapper, which decomposes operands.

---
 rtl/fpu_arbiter.sv | 149 ++++++++++++++
 tb/tb_fpu_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that shares one floating-point execution unit between N_REQ requesters.
// It runs one operation at a time and forces a result and a unit flush if the unit never answers.
//
// state   | meaning
// IDLE    | pick the next requester round-robin and accept its operands
// ISSUE   | pulse unit_valid_o and clear the wait counter
// WAIT    | wait for unit_valid_i, or force a result once TIMEOUT cycles have passed
// RESPOND | pulse rsp_valid_o to the owning requester and advance the pointer
module fpu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [2*N_REQ-1:0]   req_op_i,
    input  logic [32*N_REQ-1:0]  req_x_i,
    input  logic [32*N_REQ-1:0]  req_y_i,
    output logic [N_REQ-1:0]     rsp_valid_o,
    output logic [31:0]          rsp_z_o,
    output logic                 rsp_invalid_o,
    output logic                 rsp_overflow_o,
    output logic                 rsp_timeout_o,
    output logic                 busy_o,
    output logic                 unit_valid_o,
    output logic [1:0]           unit_op_o,
    output logic [31:0]          unit_x_o,
    output logic [31:0]          unit_y_o,
    output logic                 unit_rst_o,
    input  logic                 unit_valid_i,
    input  logic [31:0]          unit_z_i,
    input  logic                 unit_invalid_i,
    input  logic                 unit_overflow_i
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = $clog2(TIMEOUT);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   last_grant, id_q, grant_idx, cand;
    logic             grant_found;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q, sel_op;
    logic [31:0]      x_q, y_q, z_q, sel_x, sel_y;
    logic             inv_q, ovf_q, to_q;
    logic             cnt_expired;

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % N_REQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_op      = req_op_i[2*int'(grant_idx) +: 2];
    assign sel_x       = req_x_i[32*int'(grant_idx) +: 32];
    assign sel_y       = req_y_i[32*int'(grant_idx) +: 32];
    assign cnt_expired = (cnt == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (unit_valid_i || cnt_expired) state_nxt = RESPOND;
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant <= IDW'(N_REQ - 1);
            id_q       <= '0;
            cnt        <= '0;
            op_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            inv_q      <= 1'b0;
            ovf_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        id_q <= grant_idx;
                        x_q  <= sel_x;
                        // SUB becomes ADD with y's sign flipped, NaNs included.
                        case (sel_op)
                            2'd0:    begin op_q <= 2'd0; y_q <= sel_y; end
                            2'd1:    begin op_q <= 2'd0; y_q <= {~sel_y[31], sel_y[30:0]}; end
                            2'd2:    begin op_q <= 2'd1; y_q <= sel_y; end
                            default: begin op_q <= 2'd2; y_q <= sel_y; end
                        endcase
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (unit_valid_i) begin
                        z_q   <= unit_z_i;
                        inv_q <= unit_invalid_i;
                        ovf_q <= unit_overflow_i;
                        to_q  <= 1'b0;
                    end else if (cnt_expired) begin
                        z_q   <= 32'h7fff_ffff;
                        inv_q <= 1'b1;
                        ovf_q <= 1'b0;
                        to_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESPOND: last_grant <= id_q;
                default: ;
            endcase
        end
    end

    // Strobes are masked during reset so a reset cycle never looks like a handshake or response.
    assign req_ready_o    = (!rst_i && state == IDLE && grant_found) ? (ONE_HOT0 << grant_idx) : '0;
    assign rsp_valid_o    = (!rst_i && state == RESPOND) ? (ONE_HOT0 << id_q) : '0;
    assign busy_o         = !rst_i && (state != IDLE);
    assign unit_valid_o   = !rst_i && (state == ISSUE);
    assign unit_rst_o     = !rst_i && (state == WAIT) && cnt_expired && !unit_valid_i;
    assign unit_op_o      = op_q;
    assign unit_x_o       = x_q;
    assign unit_y_o       = y_q;
    assign rsp_z_o        = z_q;
    assign rsp_invalid_o  = inv_q;
    assign rsp_overflow_o = ovf_q;
    assign rsp_timeout_o  = to_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: a scripted execution-unit model with settable latency and result,
// and hand-computed expectations for grant order, latency, opcode mapping, timeout and reset.
module tb_fpu_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [N-1:0]       req_valid_i;
    logic [N-1:0]       req_ready_o;
    logic [2*N-1:0]     req_op_i;
    logic [32*N-1:0]    req_x_i;
    logic [32*N-1:0]    req_y_i;
    logic [N-1:0]       rsp_valid_o;
    logic [31:0]        rsp_z_o;
    logic               rsp_invalid_o, rsp_overflow_o, rsp_timeout_o, busy_o;
    logic               unit_valid_o, unit_rst_o;
    logic [1:0]         unit_op_o;
    logic [31:0]        unit_x_o, unit_y_o;
    logic               unit_valid_i, unit_invalid_i, unit_overflow_i;
    logic [31:0]        unit_z_i;

    fpu_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_x_i(req_x_i), .req_y_i(req_y_i),
        .rsp_valid_o(rsp_valid_o), .rsp_z_o(rsp_z_o), .rsp_invalid_o(rsp_invalid_o),
        .rsp_overflow_o(rsp_overflow_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
        .unit_valid_o(unit_valid_o), .unit_op_o(unit_op_o), .unit_x_o(unit_x_o),
        .unit_y_o(unit_y_o), .unit_rst_o(unit_rst_o),
        .unit_valid_i(unit_valid_i), .unit_z_i(unit_z_i),
        .unit_invalid_i(unit_invalid_i), .unit_overflow_i(unit_overflow_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int multi_rsp = 0;

    always @(negedge clk_i) if ($countones(rsp_valid_o) > 1) multi_rsp++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Execution-unit model: answers model_lat cycles after the start pulse.
    logic        model_en  = 1'b1;
    int          model_lat = 5;
    logic [31:0] model_z   = '0;
    logic        model_inv = 1'b0;
    logic        model_ovf = 1'b0;

    initial begin
        unit_valid_i = 1'b0; unit_z_i = '0; unit_invalid_i = 1'b0; unit_overflow_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (unit_valid_o && model_en) begin
                repeat (model_lat) @(negedge clk_i);
                unit_valid_i = 1'b1; unit_z_i = model_z;
                unit_invalid_i = model_inv; unit_overflow_i = model_ovf;
                @(negedge clk_i);
                unit_valid_i = 1'b0; unit_z_i = '0; unit_invalid_i = 1'b0; unit_overflow_i = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"},  req_ready_o, 0);
        check({tag, "_rspv"},   rsp_valid_o, 0);
        check({tag, "_z"},      rsp_z_o, 0);
        check({tag, "_flags"},  {rsp_invalid_o, rsp_overflow_o, rsp_timeout_o}, 0);
        check({tag, "_busy"},   busy_o, 0);
        check({tag, "_uvalid"}, unit_valid_o, 0);
        check({tag, "_urst"},   unit_rst_o, 0);
        check({tag, "_uop"},    unit_op_o, 0);
        check({tag, "_ux"},     unit_x_o, 0);
        check({tag, "_uy"},     unit_y_o, 0);
    endtask

    // One full transaction: handshake, issue, wait, response. exp_rst is the cycle (relative
    // to the handshake) of the unit flush, or -1 if none is expected.
    task automatic run_op(input string tag, input int idx, input logic [1:0] op,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [1:0] exp_uop, input logic [31:0] exp_uy,
                          input int exp_dly, input logic [31:0] exp_z,
                          input logic exp_inv, input logic exp_ovf, input logic exp_to,
                          input int exp_rst);
        int t0, k, rst_at, rst_cnt;
        req_op_i[2*idx +: 2]  = op;
        req_x_i[32*idx +: 32] = x;
        req_y_i[32*idx +: 32] = y;
        req_valid_i[idx]      = 1'b1;
        #1;
        k = 0;
        while (!req_ready_o[idx] && k < 50) begin step(); k++; end
        check({tag, "_ready"}, req_ready_o, 32'(1) << idx);
        t0 = cyc;
        step();
        req_valid_i[idx] = 1'b0;
        check({tag, "_uvalid"}, unit_valid_o, 1);
        check({tag, "_uop"}, unit_op_o, exp_uop);
        check({tag, "_ux"}, unit_x_o, x);
        check({tag, "_uy"}, unit_y_o, exp_uy);
        rst_at = -1; rst_cnt = 0; k = 0;
        while (rsp_valid_o == 0 && k < 200) begin
            if (unit_rst_o) begin rst_at = cyc - t0; rst_cnt++; end
            step(); k++;
        end
        check({tag, "_dly"}, cyc - t0, exp_dly);
        check({tag, "_rspv"}, rsp_valid_o, 32'(1) << idx);
        check({tag, "_z"}, rsp_z_o, exp_z);
        check({tag, "_flags"}, {rsp_invalid_o, rsp_overflow_o, rsp_timeout_o},
              {exp_inv, exp_ovf, exp_to});
        check({tag, "_urst_at"}, rst_at, exp_rst);
        check({tag, "_urst_cnt"}, rst_cnt, (exp_rst >= 0) ? 1 : 0);
        step();
        check({tag, "_pulse"}, rsp_valid_o, 0);
        check({tag, "_zhold"}, rsp_z_o, exp_z);
        check({tag, "_idle"}, busy_o, 0);
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b1;
        req_valid_i = '0;
        repeat (3) step();
        check_zero(tag);
        rst_i = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst_i = 1'b1; req_valid_i = '0; req_op_i = '0; req_x_i = '0; req_y_i = '0;
        repeat (3) step();
        check_zero("rst");
        rst_i = 1'b0;
        step();
        check_zero("post_rst");

        // ADD, req0: 1.0 + 2.0 = 3.0
        model_lat = 5; model_z = 32'h4040_0000; model_inv = 0; model_ovf = 0;
        run_op("add", 0, 2'd0, 32'h3f80_0000, 32'h4000_0000, 2'd0, 32'h4000_0000,
               7, 32'h4040_0000, 0, 0, 0, -1);

        // SUB, req2: 3.0 - 1.0, y sign flipped
        model_lat = 3; model_z = 32'h4000_0000;
        run_op("sub", 2, 2'd1, 32'h4040_0000, 32'h3f80_0000, 2'd0, 32'hbf80_0000,
               5, 32'h4000_0000, 0, 0, 0, -1);

        // Round-robin from a fresh pointer with all four requesters holding MUL.
        do_reset("rst_rr");
        model_lat = 2; model_z = 32'h4080_0000;
        for (int i = 0; i < N; i++) begin
            req_op_i[2*i +: 2]  = 2'd2;
            req_x_i[32*i +: 32] = 32'h4000_0000;
            req_y_i[32*i +: 32] = 32'h4000_0000;
        end
        req_valid_i = '1;
        #1;
        for (int g = 0; g < 6; g++) begin
            k = 0;
            while (req_ready_o == 0 && k < 50) begin step(); k++; end
            check("rr_onehot", $countones(req_ready_o), 1);
            check($sformatf("rr_grant%0d", g), req_ready_o, 32'(1) << (g % N));
            step();
            check("rr_mulop", unit_op_o, 2'd1);
        end
        req_valid_i = '0;
        k = 0;
        while (busy_o && k < 50) begin step(); k++; end
        check("rr_drain", busy_o, 0);

        // DIV by zero, req1 (last grant was 1, so 1 is searched last but alone)
        model_lat = 5; model_z = 32'h7f80_0000; model_inv = 1; model_ovf = 0;
        run_op("div0", 1, 2'd3, 32'h3f80_0000, 32'h0000_0000, 2'd2, 32'h0000_0000,
               7, 32'h7f80_0000, 1, 0, 0, -1);

        // MUL overflow, req3, shortest latency
        model_lat = 1; model_z = 32'h7f80_0000; model_inv = 0; model_ovf = 1;
        run_op("movf", 3, 2'd2, 32'h7f00_0000, 32'h7f00_0000, 2'd1, 32'h7f00_0000,
               3, 32'h7f80_0000, 0, 1, 0, -1);

        // Unit silent: timeout 64 cycles after ISSUE, i.e. handshake + 65
        model_en = 0;
        run_op("tmo", 0, 2'd0, 32'h3f80_0000, 32'h3f80_0000, 2'd0, 32'h3f80_0000,
               66, 32'h7fff_ffff, 1, 0, 1, 65);

        // Normal operation resumes
        model_en = 1; model_lat = 2; model_z = 32'h40c0_0000; model_inv = 0; model_ovf = 0;
        run_op("after_tmo", 1, 2'd2, 32'h4000_0000, 32'h4040_0000, 2'd1, 32'h4040_0000,
               4, 32'h40c0_0000, 0, 0, 0, -1);

        // Result arrives exactly in the timeout cycle: the result wins
        model_lat = 64; model_z = 32'h3f80_0000;
        run_op("edge", 2, 2'd0, 32'h3f00_0000, 32'h3f00_0000, 2'd0, 32'h3f00_0000,
               66, 32'h3f80_0000, 0, 0, 0, -1);

        // Reset mid-WAIT with a late result afterwards
        model_lat = 10; model_z = 32'h4110_0000;
        req_op_i[2*1 +: 2] = 2'd0;
        req_valid_i[1] = 1'b1;
        #1;
        k = 0;
        while (!req_ready_o[1] && k < 50) begin step(); k++; end
        step();
        req_valid_i[1] = 1'b0;
        repeat (4) step();
        check("mid_busy", busy_o, 1);
        rst_i = 1'b1;
        step();
        check_zero("mid_rst");
        step();
        rst_i = 1'b0;
        k = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (rsp_valid_o != 0 || busy_o) k++;
        end
        check("mid_no_rsp", k, 0);
        req_op_i[2*3 +: 2] = 2'd0;
        req_valid_i = 4'b1001;
        #1;
        check("mid_first_grant", req_ready_o, 4'b0001);
        req_valid_i[3] = 1'b0;
        model_lat = 3; model_z = 32'h4100_0000;
        run_op("post_mid", 0, 2'd0, 32'h4080_0000, 32'h4080_0000, 2'd0, 32'h4080_0000,
               5, 32'h4100_0000, 0, 0, 0, -1);

        check("multi_rsp", multi_rsp, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
